// File: rtl/canvas_write_arbiter.sv
// Arbitrates the canvas BRAM write port between the clear sweep, pen-stroke draws
// and camera pixels, encoding each write into the 8-bit canvas pixel format.
module canvas_write_arbiter #(
    parameter int DEPTH      = 76800,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  clear_req_in,
    output logic                  clear_busy_out,
    input  logic                  draw_valid_in,
    output logic                  draw_ready_out,
    input  logic [ADDR_WIDTH-1:0] draw_addr_in,
    input  logic [1:0]            draw_color_in,
    input  logic                  cam_valid_in,
    input  logic [ADDR_WIDTH-1:0] cam_addr_in,
    input  logic [5:0]            cam_gray_in,
    output logic [15:0]           cam_drop_count_out,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    output logic [7:0]            bram_din_out,
    output logic                  bram_we_out,
    output logic                  state_dbg_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
    logic                  hold_vld_q, hold_vld_d;
    logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [5:0]            hold_gray_q, hold_gray_d;
    logic [15:0]           drop_q, drop_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            din_q, din_d;
    logic                  busy_q, busy_d;

    logic draw_in_range;
    logic cam_take;
    logic draw_ready;
    logic draw_fire;

    // Draw handshake: a request transfers on a rising edge where draw_valid_in
    // and draw_ready_out are both high; ready never depends on valid.
    assign draw_ready    = !rst_in && (state_q == IDLE) && !clear_req_in;
    assign draw_fire     = draw_valid_in && draw_ready;
    assign draw_in_range = ({1'b0, draw_addr_in} < DEPTH_EXT);
    // Out-of-range camera pixels are consumed on arrival and never occupy the hold slot.
    assign cam_take      = cam_valid_in && ({1'b0, cam_addr_in} < DEPTH_EXT);

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        hold_vld_d  = hold_vld_q;
        hold_addr_d = hold_addr_q;
        hold_gray_d = hold_gray_q;
        drop_d      = drop_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;
        busy_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear_req_in) begin
                    // First sweep write goes out on the same edge that sees the request.
                    we_d       = 1'b1;
                    addr_d     = '0;
                    din_d      = 8'h00;
                    busy_d     = 1'b1;
                    hold_vld_d = 1'b0;
                    sweep_d    = ADDR_WIDTH'(1);
                    state_d    = (LAST_ADDR == '0) ? IDLE : CLEAR;
                end else if (draw_fire) begin
                    if (draw_in_range) begin
                        we_d   = 1'b1;
                        addr_d = draw_addr_in;
                        din_d  = {2'b11, 4'b0000, draw_color_in};
                    end
                    if (cam_take) begin
                        if (!hold_vld_q) begin
                            hold_vld_d  = 1'b1;
                            hold_addr_d = cam_addr_in;
                            hold_gray_d = cam_gray_in;
                        end else if (drop_q != 16'hFFFF) begin
                            drop_d = drop_q + 16'd1;
                        end
                    end
                end else if (hold_vld_q) begin
                    we_d        = 1'b1;
                    addr_d      = hold_addr_q;
                    din_d       = {2'b00, hold_gray_q};
                    hold_vld_d  = cam_take;
                    hold_addr_d = cam_addr_in;
                    hold_gray_d = cam_gray_in;
                end else if (cam_take) begin
                    we_d   = 1'b1;
                    addr_d = cam_addr_in;
                    din_d  = {2'b00, cam_gray_in};
                end
            end
            CLEAR: begin
                we_d    = 1'b1;
                addr_d  = sweep_q;
                din_d   = 8'h00;
                busy_d  = 1'b1;
                sweep_d = sweep_q + ADDR_WIDTH'(1);
                if (sweep_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            sweep_q     <= '0;
            hold_vld_q  <= 1'b0;
            hold_addr_q <= '0;
            hold_gray_q <= '0;
            drop_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            hold_vld_q  <= hold_vld_d;
            hold_addr_q <= hold_addr_d;
            hold_gray_q <= hold_gray_d;
            drop_q      <= drop_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            busy_q      <= busy_d;
        end
    end

    assign draw_ready_out     = draw_ready;
    assign clear_busy_out     = busy_q;
    assign cam_drop_count_out = drop_q;
    assign bram_we_out        = we_q;
    assign bram_addr_out      = addr_q;
    assign bram_din_out       = din_q;
    assign state_dbg_out      = (state_q == CLEAR);

endmodule

// File: tb/tb_canvas_write_arbiter.sv
// Bench for canvas_write_arbiter on a 16-pixel canvas: directed vector table,
// clear/reset sequences and randomized traffic against a queue-based reference model.
module tb_canvas_write_arbiter;

    localparam int DEPTH = 16;
    localparam int AW    = 5;
    localparam int W     = 27 + AW;
    localparam logic [W-1:0] DATA_MASK = {3'b111, {AW{1'b0}}, 8'h00, 16'hFFFF};

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          clear_req_in = 1'b0;
    logic          clear_busy_out;
    logic          draw_valid_in = 1'b0;
    logic          draw_ready_out;
    logic [AW-1:0] draw_addr_in = '0;
    logic [1:0]    draw_color_in = '0;
    logic          cam_valid_in = 1'b0;
    logic [AW-1:0] cam_addr_in = '0;
    logic [5:0]    cam_gray_in = '0;
    logic [15:0]   cam_drop_count_out;
    logic [AW-1:0] bram_addr_out;
    logic [7:0]    bram_din_out;
    logic          bram_we_out;
    logic          state_dbg_out;

    canvas_write_arbiter #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .clear_req_in(clear_req_in),
        .clear_busy_out(clear_busy_out), .draw_valid_in(draw_valid_in),
        .draw_ready_out(draw_ready_out), .draw_addr_in(draw_addr_in),
        .draw_color_in(draw_color_in), .cam_valid_in(cam_valid_in),
        .cam_addr_in(cam_addr_in), .cam_gray_in(cam_gray_in),
        .cam_drop_count_out(cam_drop_count_out), .bram_addr_out(bram_addr_out),
        .bram_din_out(bram_din_out), .bram_we_out(bram_we_out),
        .state_dbg_out(state_dbg_out)
    );

    // clock
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // reference model: pending sweep writes, a one-deep camera hold queue, drop count
    typedef struct packed {
        logic [AW-1:0] a;
        logic [5:0]    g;
    } cam_px_t;

    int          m_sweep_left = 0;
    int          m_drop = 0;
    cam_px_t     m_hold[$];
    logic [W-1:0] exp_q[$];

    function automatic logic model_ready(input logic r, input logic c);
        return !r && (m_sweep_left == 0) && !c;
    endfunction

    task automatic model_step(input logic r, input logic c, input logic dv,
                              input logic [AW-1:0] da, input logic [1:0] dc,
                              input logic cv, input logic [AW-1:0] ca, input logic [5:0] cg);
        logic          we = 1'b0;
        logic          busy = 1'b0;
        logic [AW-1:0] a = '0;
        logic [7:0]    d = '0;
        logic          cam_ok;
        cam_px_t       px;
        cam_ok = cv && (int'(ca) < DEPTH);
        if (r) begin
            m_sweep_left = 0;
            m_drop = 0;
            m_hold.delete();
        end else if (m_sweep_left > 0) begin
            we = 1'b1; busy = 1'b1;
            a = AW'(DEPTH - m_sweep_left);
            m_sweep_left--;
        end else if (c) begin
            we = 1'b1; busy = 1'b1; a = '0;
            m_sweep_left = DEPTH - 1;
            m_hold.delete();
        end else if (dv) begin
            if (int'(da) < DEPTH) begin
                we = 1'b1; a = da; d = {6'b110000, dc};
            end
            if (cam_ok) begin
                if (m_hold.size() == 0) m_hold.push_back('{ca, cg});
                else if (m_drop < 65535) m_drop++;
            end
        end else if (m_hold.size() > 0) begin
            px = m_hold.pop_front();
            we = 1'b1; a = px.a; d = {2'b00, px.g};
            if (cam_ok) m_hold.push_back('{ca, cg});
        end else if (cam_ok) begin
            we = 1'b1; a = ca; d = {2'b00, cg};
        end
        exp_q.push_back({m_sweep_left > 0, busy, we, a, d, 16'(m_drop)});
    endtask

    task automatic compare_out();
        logic [W-1:0] exp;
        logic [W-1:0] act;
        exp = exp_q.pop_front();
        act = {state_dbg_out, clear_busy_out, bram_we_out, bram_addr_out, bram_din_out,
               cam_drop_count_out};
        if (!exp[24+AW]) begin
            exp = exp & DATA_MASK;
            act = act & DATA_MASK;
        end
        check("model_out", 64'(act), 64'(exp));
    endtask

    // driver: apply one cycle of inputs, check ready, advance, check registered outputs
    task automatic cycle(input logic r, input logic c, input logic dv,
                         input logic [AW-1:0] da, input logic [1:0] dc,
                         input logic cv, input logic [AW-1:0] ca, input logic [5:0] cg,
                         output logic rdy_seen);
        rst_in = r; clear_req_in = c; draw_valid_in = dv; draw_addr_in = da;
        draw_color_in = dc; cam_valid_in = cv; cam_addr_in = ca; cam_gray_in = cg;
        #1;
        rdy_seen = draw_ready_out;
        check("draw_ready", 64'(draw_ready_out), 64'(model_ready(r, c)));
        model_step(r, c, dv, da, dc, cv, ca, cg);
        @(posedge clk_in);
        #1;
        compare_out();
    endtask

    typedef struct {
        logic          r, c, dv;
        logic [AW-1:0] da;
        logic [1:0]    dc;
        logic          cv;
        logic [AW-1:0] ca;
        logic [5:0]    cg;
        logic          rdy, we;
        logic [AW-1:0] addr;
        logic [7:0]    din;
        logic [15:0]   drop;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic rdy;
        // reset; draw; camera; draw+cam then idle; three draw+cam; out-of-range cases
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 5'd0,  8'h00, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 5'd5,  2'd2, 1'b0, 5'd0,  6'h00, 1'b1, 1'b1, 5'd5,  8'hC2, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 1'b1, 5'd10, 6'h2A, 1'b1, 1'b1, 5'd10, 8'h2A, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 5'd3,  2'd1, 1'b1, 5'd4,  6'h05, 1'b1, 1'b1, 5'd3,  8'hC1, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 5'd0,  6'h00, 1'b1, 1'b1, 5'd4,  8'h05, 16'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 5'd0,  8'h00, 16'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 5'd1,  2'd0, 1'b1, 5'd7,  6'h11, 1'b1, 1'b1, 5'd1,  8'hC0, 16'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 5'd2,  2'd3, 1'b1, 5'd8,  6'h12, 1'b1, 1'b1, 5'd2,  8'hC3, 16'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 5'd6,  2'd1, 1'b1, 5'd9,  6'h13, 1'b1, 1'b1, 5'd6,  8'hC1, 16'd2};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 5'd0,  6'h00, 1'b1, 1'b1, 5'd7,  8'h11, 16'd2};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 5'd16, 2'd1, 1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 5'd0,  8'h00, 16'd2};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 1'b1, 5'd20, 6'h3F, 1'b1, 1'b0, 5'd0,  8'h00, 16'd2};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 5'd15, 2'd2, 1'b1, 5'd31, 6'h01, 1'b1, 1'b1, 5'd15, 8'hC2, 16'd2};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 5'd0,  8'h00, 16'd2};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 1'b1, 5'd12, 6'h07, 1'b1, 1'b1, 5'd12, 8'h07, 16'd2};

        @(posedge clk_in);
        #1;
        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].r, vecs[i].c, vecs[i].dv, vecs[i].da, vecs[i].dc,
                  vecs[i].cv, vecs[i].ca, vecs[i].cg, rdy);
            check($sformatf("vec%0d_rdy", i), 64'(rdy), 64'(vecs[i].rdy));
            check($sformatf("vec%0d_we", i), 64'(bram_we_out), 64'(vecs[i].we));
            if (vecs[i].we) begin
                check($sformatf("vec%0d_addr", i), 64'(bram_addr_out), 64'(vecs[i].addr));
                check($sformatf("vec%0d_din", i), 64'(bram_din_out), 64'(vecs[i].din));
            end
            check($sformatf("vec%0d_drop", i), 64'(cam_drop_count_out), 64'(vecs[i].drop));
        end

        // clear with a held camera pixel; draw offered alongside the request is refused
        cycle(1'b0, 1'b0, 1'b1, 5'd0, 2'd1, 1'b1, 5'd9, 6'h3F, rdy);
        cycle(1'b0, 1'b1, 1'b1, 5'd1, 2'd1, 1'b1, 5'd3, 6'h22, rdy);
        check("clr_start_rdy", 64'(rdy), 64'(0));
        check("clr_start_we", 64'(bram_we_out), 64'(1));
        check("clr_start_addr", 64'(bram_addr_out), 64'(0));
        check("clr_start_busy", 64'(clear_busy_out), 64'(1));
        for (int j = 1; j < DEPTH; j++) begin
            cycle(1'b0, (j == 3), 1'b1, 5'd12, 2'd3, 1'b1, 5'd9, 6'h15, rdy);
            check($sformatf("clr_rdy%0d", j), 64'(rdy), 64'(0));
            check($sformatf("clr_addr%0d", j), 64'(bram_addr_out), 64'(j));
            check($sformatf("clr_din%0d", j), 64'(bram_din_out), 64'(0));
            check($sformatf("clr_busy%0d", j), 64'(clear_busy_out), 64'(1));
        end
        cycle(1'b0, 1'b0, 1'b1, 5'd12, 2'd3, 1'b0, 5'd0, 6'h00, rdy);
        check("post_clr_rdy", 64'(rdy), 64'(1));
        check("post_clr_busy", 64'(clear_busy_out), 64'(0));
        check("post_clr_draw", 64'({bram_we_out, bram_addr_out, bram_din_out}),
              64'({1'b1, 5'd12, 8'hC3}));
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 6'h00, rdy);
        check("held_discarded", 64'(bram_we_out), 64'(0));

        // reset while the sweep shows write 7
        cycle(1'b0, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 6'h00, rdy);
        for (int j = 1; j <= 7; j++) cycle(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 6'h00, rdy);
        check("sweep_addr7", 64'(bram_addr_out), 64'(7));
        cycle(1'b1, 1'b0, 1'b1, 5'd4, 2'd2, 1'b1, 5'd4, 6'h01, rdy);
        check("rst_mid_we", 64'(bram_we_out), 64'(0));
        check("rst_mid_busy", 64'(clear_busy_out), 64'(0));
        cycle(1'b0, 1'b0, 1'b1, 5'd4, 2'd2, 1'b0, 5'd0, 6'h00, rdy);
        check("rst_then_draw", 64'({bram_we_out, bram_addr_out, bram_din_out}),
              64'({1'b1, 5'd4, 8'hC2}));

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 19)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 19)), 6'($urandom_range(0, 63)),
                  rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
